// File: rtl/out_reg_bank_if.sv
// Handshake/bus bundle for out_reg_bank: fabric-side master drives data and
// controls, the register bank (slave) returns the pad-side data and status.
interface out_reg_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             ce;
  logic             clr;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic [CW-1:0]    in_flight;
  logic             empty;

  modport master (
    output ce, clr, data_in, valid_in, sel,
    input  data_out, valid_out, in_flight, empty
  );

  modport slave (
    input  ce, clr, data_in, valid_in, sel,
    output data_out, valid_out, in_flight, empty
  );
endinterface

// File: rtl/out_reg_bank.sv
// WIDTH-channel output register bank: DEPTH-stage registered path with a valid
// tag and in-flight count, plus a per-channel combinational bypass onto the pads.
module out_reg_bank #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic           clk,
  input logic           rst,
  out_reg_bank_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] stage;
  logic [DEPTH-1:0]            vld_pipe;
  logic [CW-1:0]               cnt;

  // Clear shares the reset path so an aborted stream leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst || bus.clr) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= RST_VAL;
      vld_pipe <= '0;
      cnt      <= '0;
    end else if (bus.ce) begin
      stage[0]    <= bus.data_in;
      vld_pipe[0] <= bus.valid_in;
      for (int k = 1; k < DEPTH; k++) begin
        stage[k]    <= stage[k-1];
        vld_pipe[k] <= vld_pipe[k-1];
      end
      cnt <= cnt + CW'(bus.valid_in) - CW'(vld_pipe[DEPTH-1]);
    end
  end

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      assign bus.data_out[i] = bus.sel[i] ? bus.data_in[i] : stage[DEPTH-1][i];
    end
  endgenerate

  // Valid follows the live input only when every channel is bypassed.
  assign bus.valid_out = (&bus.sel) ? bus.valid_in : vld_pipe[DEPTH-1];
  assign bus.in_flight = cnt;
  assign bus.empty     = (cnt == '0);
endmodule

// File: tb/tb_out_reg_bank.sv
// Bench for out_reg_bank: directed scenarios plus randomized traffic checked
// against a history-queue model of the registered path.
module tb_out_reg_bank;
  localparam int               WIDTH   = 8;
  localparam int               DEPTH   = 2;
  localparam logic [WIDTH-1:0] RST_VAL = 8'h96;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  out_reg_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  out_reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             v;
  } word_t;

  word_t hist[$];  // last DEPTH ce-qualified words since reset/clear, oldest first

  function automatic logic [WIDTH-1:0] reg_d();
    return (hist.size() == DEPTH) ? hist[0].d : RST_VAL;
  endfunction

  function automatic logic reg_v();
    return (hist.size() == DEPTH) ? hist[0].v : 1'b0;
  endfunction

  function automatic int model_cnt();
    int n = 0;
    foreach (hist[k]) n += int'(hist[k].v);
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] exp_dout();
    return (bus.sel & bus.data_in) | (~bus.sel & reg_d());
  endfunction

  function automatic logic exp_vout();
    return (&bus.sel) ? bus.valid_in : reg_v();
  endfunction

  task automatic tick();
    word_t w;
    @(posedge clk);
    if (!rst || bus.clr) hist.delete();
    else if (bus.ce) begin
      w.d = bus.data_in;
      w.v = bus.valid_in;
      hist.push_back(w);
      if (hist.size() > DEPTH) void'(hist.pop_front());
    end
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.ce = 1'b1; bus.clr = 1'b0; bus.sel = '0;
    bus.data_in = 8'hFF; bus.valid_in = 1'b1;
    tick();
    tick();
    checks++; if (bus.data_out !== RST_VAL) begin errors++; $display("FAIL reset_data got=%h exp=%h", bus.data_out, RST_VAL); end
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.valid_out); end
    checks++; if (bus.in_flight !== 2'd0) begin errors++; $display("FAIL reset_inflight got=%0d exp=0", bus.in_flight); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    bus.ce = 1'b1; bus.sel = '0; bus.data_in = 8'hA5; bus.valid_in = 1'b1;
    tick();
    checks++; if (bus.in_flight !== 2'd1) begin errors++; $display("FAIL basic_inflight0 got=%0d exp=1", bus.in_flight); end
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", bus.valid_out); end
    bus.valid_in = 1'b0; bus.data_in = 8'h11;
    tick();
    checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", bus.data_out); end
    checks++; if (bus.valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", bus.valid_out); end
    checks++; if (bus.in_flight !== 2'd1) begin errors++; $display("FAIL basic_inflight1 got=%0d exp=1", bus.in_flight); end
    tick();
    checks++; if (bus.in_flight !== 2'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL basic_drain got=%0d/%b exp=0/1", bus.in_flight, bus.empty); end
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", bus.valid_out); end
  endtask

  task automatic test_sel_mix();
    bus.clr = 1'b1; tick(); bus.clr = 1'b0;
    bus.ce = 1'b1; bus.sel = '0; bus.data_in = 8'h3C; bus.valid_in = 1'b1;
    tick();
    bus.data_in = 8'h77; bus.valid_in = 1'b0;
    tick();
    bus.ce = 1'b0; bus.sel = 8'h0F; bus.data_in = 8'hC3;
    #1;
    checks++; if (bus.data_out !== 8'h33) begin errors++; $display("FAIL sel_mix_data got=%h exp=33", bus.data_out); end
    checks++; if (bus.valid_out !== 1'b1) begin errors++; $display("FAIL sel_mix_valid got=%b exp=1", bus.valid_out); end
    bus.sel = 8'hF0;
    #1;
    checks++; if (bus.data_out !== 8'hC3 && bus.data_out !== 8'hCC) begin errors++; $display("FAIL sel_mix2 got=%h exp=cc", bus.data_out); end
    checks++; if (bus.data_out !== 8'hCC) begin errors++; $display("FAIL sel_mix2_exact got=%h exp=cc", bus.data_out); end
    bus.sel = '0;
  endtask

  task automatic test_ce_toggle();
    logic [WIDTH-1:0] got[$];
    int idx = 0;
    bus.clr = 1'b1; tick(); bus.clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.ce = (i % 2 == 0);
      if (bus.ce && idx < 3) begin
        idx++;
        bus.data_in = WIDTH'(idx); bus.valid_in = 1'b1;
      end else begin
        bus.data_in = WIDTH'($urandom); bus.valid_in = (!bus.ce) ? 1'($urandom) : 1'b0;
      end
      tick();
      checks++; if (bus.data_out !== reg_d() || bus.valid_out !== reg_v()) begin errors++; $display("FAIL ce_toggle_out cyc=%0d got=%h/%b exp=%h/%b", i, bus.data_out, bus.valid_out, reg_d(), reg_v()); end
      checks++; if (bus.in_flight > 2'd2 || int'(bus.in_flight) != model_cnt()) begin errors++; $display("FAIL ce_toggle_cnt cyc=%0d got=%0d exp=%0d", i, bus.in_flight, model_cnt()); end
      if ((i % 2 == 0) && bus.valid_out) got.push_back(bus.data_out);
    end
    checks++;
    if (got.size() != 3 || got[0] !== 8'h01 || got[1] !== 8'h02 || got[2] !== 8'h03) begin
      errors++; $display("FAIL ce_toggle_order got_n=%0d exp_n=3", got.size());
    end
  endtask

  task automatic test_clear();
    bus.sel = '0; bus.ce = 1'b1; bus.valid_in = 1'b1;
    bus.data_in = 8'h21; tick();
    bus.data_in = 8'h22; tick();
    checks++; if (bus.in_flight !== 2'd2) begin errors++; $display("FAIL clr_full got=%0d exp=2", bus.in_flight); end
    bus.clr = 1'b1; bus.data_in = 8'h23; tick(); bus.clr = 1'b0;
    checks++; if (bus.in_flight !== 2'd0 || bus.empty !== 1'b1 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL clr_drop got=%0d/%b/%b exp=0/1/0", bus.in_flight, bus.empty, bus.valid_out); end
    checks++; if (bus.data_out !== RST_VAL) begin errors++; $display("FAIL clr_data got=%h exp=%h", bus.data_out, RST_VAL); end
    bus.data_in = 8'h31; tick();
    bus.data_in = 8'h32; tick();
    bus.ce = 1'b0; rst = 1'b0; tick(); rst = 1'b1;
    checks++; if (bus.in_flight !== 2'd0 || bus.empty !== 1'b1 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL rst_drop got=%0d/%b/%b exp=0/1/0", bus.in_flight, bus.empty, bus.valid_out); end
    bus.ce = 1'b1; bus.valid_in = 1'b0; tick();
    checks++; if (bus.valid_out !== 1'b0 || bus.data_out !== RST_VAL) begin errors++; $display("FAIL rst_no_partial got=%h/%b exp=%h/0", bus.data_out, bus.valid_out, RST_VAL); end
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 4; i++) begin
      bus.sel = '0; bus.ce = 1'b1; bus.data_in = WIDTH'($urandom); bus.valid_in = 1'($urandom);
      tick();
      bus.sel = 8'hFF; bus.valid_in = 1'b1; bus.data_in = 8'h5A;
      #1;
      checks++; if (bus.data_out !== 8'h5A || bus.valid_out !== 1'b1) begin errors++; $display("FAIL bypass got=%h/%b exp=5a/1", bus.data_out, bus.valid_out); end
    end
    bus.sel = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 99) >= 3);
      bus.clr     = ($urandom_range(0, 99) < 5);
      bus.ce      = ($urandom_range(0, 99) < 70);
      bus.valid_in = 1'($urandom);
      bus.data_in = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       bus.sel = '0;
        1:       bus.sel = '1;
        default: bus.sel = WIDTH'($urandom);
      endcase
      #1;
      checks++;
      if (bus.data_out !== exp_dout() || bus.valid_out !== exp_vout() ||
          int'(bus.in_flight) != model_cnt() || bus.empty !== (model_cnt() == 0)) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h/%b/%0d/%b exp=%h/%b/%0d/%b", i, bus.data_out, bus.valid_out,
                 bus.in_flight, bus.empty, exp_dout(), exp_vout(), model_cnt(), model_cnt() == 0);
      end
      tick();
    end
    rst = 1'b1; bus.clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bus.ce = 1'b0; bus.clr = 1'b0; bus.sel = '0;
    bus.data_in = '0; bus.valid_in = 1'b0;
    test_reset();
    test_basic();
    test_sel_mix();
    test_ce_toggle();
    test_clear();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
